serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. It computes a + b + cin one bit per clock, LSB first,
// through a single full adder and a carry flop. An operation takes WIDTH
// SHIFT cycles plus a one-cycle DONE state. The minimum start-to-start
// interval is therefore WIDTH + 2 cycles.
//
// Ports
//   clk    in   rising-edge clock for all state
//   rst_n  in   asynchronous, active-low reset
//   start  in   request to begin an addition (honoured only in IDLE)
//   a, b   in   WIDTH-bit operands, sampled when start is accepted
//   cin    in   carry-in, sampled when start is accepted
//   busy   out  high while the FSM is in SHIFT
//   done   out  one-cycle pulse while the FSM is in DONE
//   sum    out  result (a + b + cin) mod 2^WIDTH, held until the next result
//   cout   out  carry-out of the addition, held like sum
//   ovf    out  (only with SERIAL_ADDER_OVF_EN) signed overflow,
//               equal to the carry into the MSB XOR cout, held like cout
//
// Configuration
//   SERIAL_ADDER_OVF_EN  define this macro to add the ovf output and its logic.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8  // legal range 2..32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // partial sum, filled from the MSB side
    logic [WIDTH-1:0] sum_q, sum_d;   // visible result, written only on the last bit
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_sum;
    logic fa_carry;
    logic last_bit;

    // One full-adder slice working on the current operand LSBs.
    assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking (=) here would create order-dependent logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (pure decode of the state, so reset clears them at once)
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (state_q == IDLE && start) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
            carry_d = fa_carry;
            cnt_d   = cnt_q + CNT_W'(1);
            // Publish the result only once the last bit has been formed, so
            // the partial sum in acc_q is never visible on sum.
            if (last_bit) begin
                sum_d  = {fa_sum, acc_q[WIDTH-1:1]};
                cout_d = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                // carry_q is the carry into the MSB during the final slice.
                ovf_d  = carry_q ^ fa_carry;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
